// File: rtl/link_retimer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pkg_en : token types, FIFO entry layout and framing states for link_retimer |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package pkg_en;

  localparam int LINK_RT_WIDTH_DATA = 32;
  localparam int LINK_RT_SLACK      = 2;

  typedef struct packed {
    logic                          v;
    logic                          a;
    logic                          r;
    logic                          c;
    logic [LINK_RT_WIDTH_DATA-1:0] d;
  } FTk_c_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_c_t;

  typedef struct packed {
    logic                          a;
    logic                          r;
    logic                          c;
    logic [LINK_RT_WIDTH_DATA-1:0] d;
  } link_ent_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } link_state_t;

endpackage : pkg_en
`default_nettype wire

// File: rtl/link_retimer_fifo_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | link_fifo_ch : one-channel token FIFO with registered nack and framing FSM  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module link_fifo_ch
  import pkg_en::*;
#(
  parameter int WIDTH_DATA = LINK_RT_WIDTH_DATA,
  parameter int DEPTH_FIFO = 4,
  parameter int SLACK      = LINK_RT_SLACK
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_v,
  input  logic                  i_a,
  input  logic                  i_r,
  input  logic                  i_c,
  input  logic [WIDTH_DATA-1:0] i_d,
  input  logic                  i_nack,
  output logic                  o_v,
  output logic [WIDTH_DATA+2:0] o_ent,
  output logic                  o_nack,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int c_addr_w = $clog2(DEPTH_FIFO);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH_FIFO);
  localparam logic [c_cnt_w-1:0] c_thresh = c_cnt_w'(DEPTH_FIFO - SLACK);

  logic [WIDTH_DATA+2:0] r_mem [DEPTH_FIFO];
  logic [c_addr_w-1:0]   r_wr_ptr;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_cnt_w-1:0]    r_rel_cnt;
  logic                  r_nack;
  logic                  r_err;
  logic                  r_open;
  link_state_t           r_state;

  logic [WIDTH_DATA+2:0] w_head;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_ovf;
  logic                  w_rel_push;
  logic                  w_rel_pop;
  logic                  w_open_next;
  logic [c_cnt_w-1:0]    w_count_next;
  logic [c_cnt_w-1:0]    w_rel_next;

  assign w_head = r_mem[r_rd_ptr];
  assign o_v    = (r_count != '0);
  assign w_full = (r_count == c_depth);
  assign w_pop  = o_v && !i_nack;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr   = i_v && (!w_full || w_pop);
  assign w_ovf  = i_v && w_full && !w_pop;

  assign w_count_next = r_count + c_cnt_w'(w_wr) - c_cnt_w'(w_pop);

  // Releases queued but not yet delivered; lets several streams sit in the FIFO.
  assign w_rel_push  = w_wr && i_r && (i_a || (r_state != ST_IDLE));
  assign w_rel_pop   = w_pop && w_head[WIDTH_DATA+1] && (r_rel_cnt != '0);
  assign w_rel_next  = r_rel_cnt + c_cnt_w'(w_rel_push) - c_cnt_w'(w_rel_pop);
  assign w_open_next = (w_wr && i_r) ? 1'b0 : ((w_wr && i_a) ? 1'b1 : r_open);

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {i_a, i_r, i_c, i_d};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rel_cnt <= '0;
      r_nack    <= 1'b0;
      r_err     <= 1'b0;
      r_open    <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
      end
      if (w_ovf) begin
        r_err <= 1'b1;
      end
      r_count   <= w_count_next;
      r_rel_cnt <= w_rel_next;
      r_nack    <= (w_count_next >= c_thresh);
      r_open    <= w_open_next;
      case (r_state)
        ST_IDLE: begin
          if (w_wr && i_a) begin
            r_state <= i_r ? ST_FLUSH : ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_wr && i_r) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_rel_next == '0) begin
            r_state <= w_open_next ? ST_STREAM : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_ent  = w_head;
  assign o_nack = r_nack;
  assign o_busy = (r_state != ST_IDLE);
  assign o_err  = r_err;

endmodule : link_fifo_ch
`default_nettype wire

// File: rtl/link_retimer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | link_retimer : registered, buffered hop on an inter-PE link                 |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module link_retimer
  import pkg_en::*;
#(
  parameter int WIDTH_DATA  = LINK_RT_WIDTH_DATA,
  parameter int NUM_CHANNEL = 1,
  parameter int DEPTH_FIFO  = 4,
  parameter int SLACK       = LINK_RT_SLACK
) (
  input  logic                              clock,
  input  logic                              reset,
  input  FTk_c_t     [NUM_CHANNEL-1:0]      I_FTk,
  output BTk_c_t     [NUM_CHANNEL-1:0]      O_BTk,
  output FTk_c_t     [NUM_CHANNEL-1:0]      O_FTk,
  input  BTk_c_t     [NUM_CHANNEL-1:0]      I_BTk,
  input  logic       [1:0]                  I_InC,
  output logic       [1:0]                  O_InC,
  output logic       [NUM_CHANNEL-1:0]      O_Busy,
  output logic       [NUM_CHANNEL-1:0]      O_Err
);

  logic [1:0] r_inc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inc <= 2'b00;
    end else begin
      r_inc <= I_InC;
    end
  end

  assign O_InC = r_inc;

  for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_ch
    logic      w_v;
    logic      w_nack;
    link_ent_t w_head;
    logic [2:0] r_btk;

    link_fifo_ch #(
      .WIDTH_DATA (WIDTH_DATA),
      .DEPTH_FIFO (DEPTH_FIFO),
      .SLACK      (SLACK)
    ) u_fifo (
      .clock  (clock),
      .reset  (reset),
      .i_v    (I_FTk[g].v),
      .i_a    (I_FTk[g].a),
      .i_r    (I_FTk[g].r),
      .i_c    (I_FTk[g].c),
      .i_d    (I_FTk[g].d),
      .i_nack (I_BTk[g].n),
      .o_v    (w_v),
      .o_ent  (w_head),
      .o_nack (w_nack),
      .o_busy (O_Busy[g]),
      .o_err  (O_Err[g])
    );

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_btk <= 3'b000;
      end else begin
        r_btk <= {I_BTk[g].t, I_BTk[g].v, I_BTk[g].c};
      end
    end

    // Entry layout is the forward token minus its valid bit.
    assign O_FTk[g] = {w_v, w_head};
    assign O_BTk[g] = {w_nack, r_btk};
  end

endmodule : link_retimer
`default_nettype wire

// File: tb/tb_link_retimer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_link_retimer : scoreboard-based bench for link_retimer                   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_link_retimer;
  import pkg_en::*;

  logic             clock;
  logic             reset;
  FTk_c_t [0:0]     I_FTk;
  BTk_c_t [0:0]     O_BTk;
  FTk_c_t [0:0]     O_FTk;
  BTk_c_t [0:0]     I_BTk;
  logic   [1:0]     I_InC;
  logic   [1:0]     O_InC;
  logic   [0:0]     O_Busy;
  logic   [0:0]     O_Err;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];
  logic [31:0] exp_d;

  link_retimer #(
    .WIDTH_DATA  (32),
    .NUM_CHANNEL (1),
    .DEPTH_FIFO  (4),
    .SLACK       (2)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .I_FTk  (I_FTk),
    .O_BTk  (O_BTk),
    .O_FTk  (O_FTk),
    .I_BTk  (I_BTk),
    .I_InC  (I_InC),
    .O_InC  (O_InC),
    .O_Busy (O_Busy),
    .O_Err  (O_Err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every token that leaves downstream must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset && O_FTk[0].v && !I_BTk[0].n) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_extra got=%h expected=none", O_FTk[0].d);
      end else begin
        exp_d = exp_q.pop_front();
        if (O_FTk[0].d !== exp_d) begin
          bad++;
          $display("FAIL scoreboard_data got=%h expected=%h", O_FTk[0].d, exp_d);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input bit a, input bit r, input logic [31:0] d);
    cyc();
    I_FTk[0].v = v;
    I_FTk[0].a = a;
    I_FTk[0].r = r;
    I_FTk[0].c = 1'b0;
    I_FTk[0].d = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    I_FTk[0].v = 1'b1;
    I_FTk[0].d = 32'hAA;
    I_InC = 2'b11;
    @(negedge clock);
    @(negedge clock);
    total++; if (O_FTk[0].v !== 1'b0) begin bad++; $display("FAIL reset_ftk_v got=%b expected=0", O_FTk[0].v); end
    total++; if (O_BTk[0] !== 4'b0000) begin bad++; $display("FAIL reset_btk got=%b expected=0000", O_BTk[0]); end
    total++; if (O_Err[0] !== 1'b0) begin bad++; $display("FAIL reset_err got=%b expected=0", O_Err[0]); end
    total++; if (O_Busy[0] !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b expected=0", O_Busy[0]); end
    total++; if (O_InC !== 2'b00) begin bad++; $display("FAIL reset_inc got=%b expected=00", O_InC); end
    reset = 1'b1;
    I_FTk[0].v = 1'b0;
    I_BTk[0].t = 1'b1;
    I_BTk[0].c = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h5A);
    exp_q.push_back(32'h5A);
    @(negedge clock);
    total++; if (O_FTk[0].v !== 1'b0) begin bad++; $display("FAIL first_push_early got=%b expected=0", O_FTk[0].v); end
    total++; if (O_InC !== 2'b11) begin bad++; $display("FAIL inc_reg got=%b expected=11", O_InC); end
    total++; if (O_BTk[0] !== 4'b0101) begin bad++; $display("FAIL btk_reg got=%b expected=0101", O_BTk[0]); end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    I_InC = 2'b10;
    I_BTk[0].t = 1'b0;
    I_BTk[0].c = 1'b0;
    @(negedge clock);
    total++; if (O_FTk[0].v !== 1'b1 || O_FTk[0].d !== 32'h5A) begin bad++; $display("FAIL first_push_latency got=%b/%h expected=1/0000005a", O_FTk[0].v, O_FTk[0].d); end
    cyc();
    @(negedge clock);
    total++; if (O_FTk[0].v !== 1'b0) begin bad++; $display("FAIL drained got=%b expected=0", O_FTk[0].v); end
    total++; if (O_InC !== 2'b10) begin bad++; $display("FAIL inc_follow got=%b expected=10", O_InC); end
  endtask

  task automatic test_fill_overflow();
    drive(1'b1, 1'b1, 1'b0, 32'h11);
    I_BTk[0].n = 1'b1;
    exp_q.push_back(32'h11);
    drive(1'b1, 1'b0, 1'b0, 32'h22);
    exp_q.push_back(32'h22);
    @(negedge clock);
    total++; if (O_BTk[0].n !== 1'b0) begin bad++; $display("FAIL nack_early got=%b expected=0", O_BTk[0].n); end
    total++; if (O_Busy[0] !== 1'b1) begin bad++; $display("FAIL busy_stream got=%b expected=1", O_Busy[0]); end
    drive(1'b1, 1'b0, 1'b0, 32'h33);
    exp_q.push_back(32'h33);
    @(negedge clock);
    total++; if (O_BTk[0].n !== 1'b1) begin bad++; $display("FAIL nack_assert got=%b expected=1", O_BTk[0].n); end
    drive(1'b1, 1'b0, 1'b0, 32'h44);
    exp_q.push_back(32'h44);
    drive(1'b1, 1'b0, 1'b0, 32'h55);
    @(negedge clock);
    total++; if (O_Err[0] !== 1'b0) begin bad++; $display("FAIL err_when_full got=%b expected=0", O_Err[0]); end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    total++; if (O_Err[0] !== 1'b1) begin bad++; $display("FAIL err_overflow got=%b expected=1", O_Err[0]); end
    total++; if (O_FTk[0].v !== 1'b1 || O_FTk[0].d !== 32'h11) begin bad++; $display("FAIL head_hold got=%b/%h expected=1/00000011", O_FTk[0].v, O_FTk[0].d); end
  endtask

  task automatic test_push_pop_full();
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    total++; if (O_Err[0] !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b expected=0", O_Err[0]); end
    drive(1'b1, 1'b1, 1'b0, 32'h11); exp_q.push_back(32'h11);
    drive(1'b1, 1'b0, 1'b0, 32'h22); exp_q.push_back(32'h22);
    drive(1'b1, 1'b0, 1'b0, 32'h33); exp_q.push_back(32'h33);
    drive(1'b1, 1'b0, 1'b0, 32'h44); exp_q.push_back(32'h44);
    drive(1'b1, 1'b0, 1'b0, 32'h55); exp_q.push_back(32'h55);
    I_BTk[0].n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    total++; if (O_Err[0] !== 1'b0) begin bad++; $display("FAIL err_pushpop got=%b expected=0", O_Err[0]); end
    total++; if (O_BTk[0].n !== 1'b1) begin bad++; $display("FAIL nack_full got=%b expected=1", O_BTk[0].n); end
    repeat (4) cyc();
    @(negedge clock);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL order_drain got=%0d left expected=0", exp_q.size()); end
    total++; if (O_FTk[0].v !== 1'b0) begin bad++; $display("FAIL empty_after got=%b expected=0", O_FTk[0].v); end
    total++; if (O_BTk[0].n !== 1'b0) begin bad++; $display("FAIL nack_release got=%b expected=0", O_BTk[0].n); end
  endtask

  task automatic test_framing();
    bit seen;
    seen = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h101); I_BTk[0].n = 1'b1; exp_q.push_back(32'h101);
    drive(1'b1, 1'b0, 1'b0, 32'h102); exp_q.push_back(32'h102);
    drive(1'b1, 1'b0, 1'b1, 32'h103); exp_q.push_back(32'h103);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    cyc();
    @(negedge clock);
    total++; if (O_Busy[0] !== 1'b1) begin bad++; $display("FAIL busy_flush got=%b expected=1", O_Busy[0]); end
    cyc();
    I_BTk[0].n = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (O_FTk[0].v && O_FTk[0].r) begin
        seen = 1'b1;
        total++; if (O_Busy[0] !== 1'b1) begin bad++; $display("FAIL busy_before_release got=%b expected=1", O_Busy[0]); end
        @(negedge clock);
        total++; if (O_Busy[0] !== 1'b0) begin bad++; $display("FAIL busy_after_release got=%b expected=0", O_Busy[0]); end
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL framing_timeout got=no_release expected=release");
    end
  endtask

  task automatic test_back_to_back();
    int rel_seen;
    bit pend;
    bit done;
    bit exp_busy;
    rel_seen = 0;
    pend = 1'b0;
    done = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h201); I_BTk[0].n = 1'b1; exp_q.push_back(32'h201);
    drive(1'b1, 1'b1, 1'b1, 32'h202); exp_q.push_back(32'h202);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    total++; if (O_Busy[0] !== 1'b1) begin bad++; $display("FAIL b2b_busy_queued got=%b expected=1", O_Busy[0]); end
    cyc();
    I_BTk[0].n = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clock);
      if (pend) begin
        exp_busy = (rel_seen < 2);
        total++; if (O_Busy[0] !== exp_busy) begin bad++; $display("FAIL b2b_busy_rel%0d got=%b expected=%b", rel_seen, O_Busy[0], exp_busy); end
        pend = 1'b0;
        if (rel_seen == 2) done = 1'b1;
      end
      if (O_FTk[0].v && O_FTk[0].r) begin
        rel_seen++;
        pend = 1'b1;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL b2b_timeout got=%0d releases expected=2", rel_seen);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h301); I_BTk[0].n = 1'b1; exp_q.push_back(32'h301);
    drive(1'b1, 1'b0, 1'b0, 32'h302); exp_q.push_back(32'h302);
    drive(1'b1, 1'b0, 1'b0, 32'h303); exp_q.push_back(32'h303);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    total++; if (O_FTk[0].v !== 1'b1 || O_Busy[0] !== 1'b1) begin bad++; $display("FAIL pre_reset got=%b/%b expected=1/1", O_FTk[0].v, O_Busy[0]); end
    reset = 1'b0;
    exp_q.delete();
    #1;
    total++; if (O_FTk[0].v !== 1'b0) begin bad++; $display("FAIL async_reset_v got=%b expected=0", O_FTk[0].v); end
    I_BTk[0].n = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      total++; if (O_FTk[0].v !== 1'b0) begin bad++; $display("FAIL stale_token got=%b expected=0", O_FTk[0].v); end
    end
    total++; if (O_Busy[0] !== 1'b0) begin bad++; $display("FAIL busy_after_reset got=%b expected=0", O_Busy[0]); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    I_FTk = '0;
    I_BTk = '0;
    I_InC = 2'b00;
    test_reset();
    test_fill_overflow();
    test_push_pop_full();
    test_framing();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule : tb_link_retimer
`default_nettype wire
